// File: rtl/load_response_aligner.sv
// load_response_aligner
// Memory-stage load unit. Takes one load (address + mode) from the pipeline,
// issues a single aligned 8-byte read on the data bus, extracts the addressed
// byte/half/word/double from the returned data, sign- or zero-extends it and
// holds the 64-bit result until the pipeline takes it. Faulting loads
// (illegal mode, or misaligned when CHECK_ALIGN=1) skip the bus entirely.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Once valid is raised, valid and its payload stay stable until
// that transfer. The dbus read completes on dresp_data_ok; dresp_addr_ok is
// informational and does not affect sequencing.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   req_*               load request from the pipeline (valid/ready)
//   dreq_*              aligned 8-byte read request to the dbus
//   dresp_*             dbus response (addr_ok ignored, data_ok + data)
//   resp_*              extended load result to the pipeline (valid/ready)
//   state               current FSM state (0 IDLE, 1 REQ, 2 RESP) for debug
module load_response_aligner #(
  parameter logic [2:0] MSIZE8_ENC  = 3'b011,
  parameter bit         CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_mode,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_misaligned,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     st;
  logic [2:0] off_q;   // byte offset inside the 8-byte line
  logic [2:0] mode_q;  // mode[3] is only needed for the fault check

  // Address acceptance is not needed for sequencing.
  logic unused_addr_ok;
  assign unused_addr_ok = dresp_addr_ok;

  assign dreq_size   = MSIZE8_ENC;
  assign dreq_strobe = 8'h00;
  assign state       = st;

  function automatic logic is_fault(input logic [3:0] mode, input logic [2:0] a);
    logic f;
    f = mode[3] | (mode == 4'b0111);
    if (CHECK_ALIGN) begin
      case (mode[1:0])
        2'b01:   f = f | a[0];
        2'b10:   f = f | (|a[1:0]);
        2'b11:   f = f | (|a);
        default: ;
      endcase
    end
    return f;
  endfunction

  // Lane offsets are snapped to the natural boundary of the access size; with
  // alignment checking on this is a no-op because misaligned loads never get
  // here, with it off it defines which lane a misaligned access reads.
  function automatic logic [63:0] fmt(input logic [2:0] mode, input logic [2:0] o,
                                      input logic [63:0] d);
    logic [63:0] r;
    logic [5:0]  base;
    r    = d;
    base = 6'd0;
    case (mode[1:0])
      2'b00: begin
        base = {o, 3'b000};
        r    = mode[2] ? {56'd0, d[base +: 8]} : {{56{d[base + 6'd7]}}, d[base +: 8]};
      end
      2'b01: begin
        base = {o[2:1], 4'b0000};
        r    = mode[2] ? {48'd0, d[base +: 16]} : {{48{d[base + 6'd15]}}, d[base +: 16]};
      end
      2'b10: begin
        base = {o[2], 5'b00000};
        r    = mode[2] ? {32'd0, d[base +: 32]} : {{32{d[base + 6'd31]}}, d[base +: 32]};
      end
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st              <= IDLE;
      off_q           <= 3'd0;
      mode_q          <= 3'd0;
      req_ready       <= 1'b1;
      dreq_valid      <= 1'b0;
      dreq_addr       <= 64'd0;
      resp_valid      <= 1'b0;
      resp_data       <= 64'd0;
      resp_misaligned <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (req_valid) begin
            off_q     <= req_addr[2:0];
            mode_q    <= req_mode[2:0];
            req_ready <= 1'b0;
            if (is_fault(req_mode, req_addr[2:0])) begin
              st              <= RESP;
              resp_valid      <= 1'b1;
              resp_data       <= 64'd0;
              resp_misaligned <= 1'b1;
            end else begin
              st         <= REQ;
              dreq_valid <= 1'b1;
              dreq_addr  <= {req_addr[63:3], 3'b000};
            end
          end
        end
        REQ: begin
          if (dresp_data_ok) begin
            st              <= RESP;
            dreq_valid      <= 1'b0;
            resp_valid      <= 1'b1;
            resp_data       <= fmt(mode_q, off_q, dresp_data);
            resp_misaligned <= 1'b0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            st         <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          st         <= IDLE;
          req_ready  <= 1'b1;
          dreq_valid <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
